// File: rtl/configs_stream_loader_if.sv
// Stream and status bundle between the fabric configuration controller and one tile's config loader.
// The controller uses the master modport and the loader uses the slave modport.
interface configs_stream_loader_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 36,
  parameter int CNT_W     = 6
);
  logic                        io_start;
  logic [WORD_W-1:0]           io_d_in;
  logic                        io_d_in_valid;
  logic                        io_d_in_ready;
  logic                        io_busy;
  logic                        io_done;
  logic [CNT_W-1:0]            io_word_cnt;
  logic                        io_err;
  logic [WORD_W*NUM_WORDS-1:0] io_configs_out;

  modport master (
    output io_start, io_d_in, io_d_in_valid,
    input  io_d_in_ready, io_busy, io_done, io_word_cnt, io_err, io_configs_out
  );

  modport slave (
    input  io_start, io_d_in, io_d_in_valid,
    output io_d_in_ready, io_busy, io_done, io_word_cnt, io_err, io_configs_out
  );
endinterface

// File: rtl/configs_stream_loader.sv
// Tile configuration loader: streams words into a flop bank using an auto-incrementing pointer.
// Defining CFG_CHECKSUM_EN adds a trailing XOR checksum word that drives io_err.
//
// state | meaning
// IDLE  | no sequence since reset; input stream not accepted
// LOAD  | accepting words (and the checksum word when enabled)
// DONE  | full sequence completed; waiting for the next start
module configs_stream_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 36,
  parameter int CNT_W     = 6
) (
  input logic                    clk,
  input logic                    reset,
  configs_stream_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);
`ifdef CFG_CHECKSUM_EN
  localparam logic [CNT_W-1:0] END_IDX = NUM_WORDS_C;
`else
  localparam logic [CNT_W-1:0] END_IDX = CNT_W'(NUM_WORDS - 1);
`endif

  state_t                              state, state_nxt;
  logic   [CNT_W-1:0]                  cnt;
  logic   [NUM_WORDS-1:0][WORD_W-1:0]  words;
  logic                                ready;
  logic                                fire;
  logic                                last_fire;

  assign fire      = bus.io_d_in_valid && ready;
  assign last_fire = fire && (cnt == END_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.io_start) state_nxt = LOAD;
      LOAD:    if (!bus.io_start && last_fire) state_nxt = DONE;
      DONE:    if (bus.io_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    bus.io_busy = 1'b0;
    bus.io_done = 1'b0;
    case (state)
      LOAD: begin
        ready       = 1'b1;
        bus.io_busy = 1'b1;
      end
      DONE:    bus.io_done = 1'b1;
      default: ;
    endcase
  end

  // Start has priority over a coinciding fire: the pointer rewinds and that word is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      words <= '0;
    end else if (bus.io_start) begin
      cnt <= '0;
    end else if (fire) begin
      if (cnt < NUM_WORDS_C) words[cnt] <= bus.io_d_in;
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0] xor_acc;
  logic              err_q;

  // The word fired at pointer NUM_WORDS is the checksum; it is compared, never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_acc <= '0;
      err_q   <= 1'b0;
    end else if (bus.io_start) begin
      xor_acc <= '0;
      err_q   <= 1'b0;
    end else if (fire) begin
      if (cnt < NUM_WORDS_C) xor_acc <= xor_acc ^ bus.io_d_in;
      else                   err_q   <= (bus.io_d_in != xor_acc);
    end
  end

  assign bus.io_err = err_q;
`else
  assign bus.io_err = 1'b0;
`endif

  assign bus.io_d_in_ready  = ready;
  assign bus.io_word_cnt    = cnt;
  assign bus.io_configs_out = words;
endmodule

// File: tb/tb_configs_stream_loader.sv
// Self-checking bench for configs_stream_loader against a word-array reference model.
// Build with CFG_CHECKSUM_EN to exercise the trailing checksum word.
module tb_configs_stream_loader;
  localparam int WW = 32;
  localparam int NW = 36;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  configs_stream_loader_if #(.WORD_W(WW), .NUM_WORDS(NW), .CNT_W(CW)) bus ();

  configs_stream_loader #(.WORD_W(WW), .NUM_WORDS(NW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: stored words, words accepted so far, and sequence flags.
  logic [WW-1:0] m_words [NW];
  int            m_cnt;
  bit            m_load, m_done, m_err;
  logic [WW-1:0] m_xor;

  function automatic logic [WW*NW-1:0] m_flat();
    logic [WW*NW-1:0] r;
    for (int k = 0; k < NW; k++) r[WW*k +: WW] = m_words[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_words[k] = '0;
    m_cnt = 0; m_load = 0; m_done = 0; m_err = 0; m_xor = '0;
  endtask

  task automatic model_edge(input bit st, input bit vld, input logic [WW-1:0] d);
    if (st) begin
      m_load = 1; m_done = 0; m_err = 0; m_cnt = 0; m_xor = '0;
    end else if (m_load && vld) begin
      if (m_cnt < NW) begin
        m_words[m_cnt] = d;
        m_xor = m_xor ^ d;
        m_cnt++;
`ifndef CFG_CHECKSUM_EN
        if (m_cnt == NW) begin m_load = 0; m_done = 1; end
`endif
      end else begin
        m_err  = (d != m_xor);
        m_cnt++;
        m_load = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic cyc(input bit st, input bit vld, input logic [WW-1:0] d);
    reset             = 1'b0;
    bus.io_start      = st;
    bus.io_d_in_valid = vld;
    bus.io_d_in       = d;
    @(posedge clk);
    model_edge(st, vld, d);
    #1;
    bus.io_start      = 1'b0;
    bus.io_d_in_valid = 1'b0;
  endtask

  task automatic rst_cyc();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  // Streams NW words with valid held high, plus the correct checksum word when enabled.
  task automatic stream_all(input logic [WW-1:0] data [NW]);
    for (int k = 0; k < NW; k++) cyc(1'b0, 1'b1, data[k]);
`ifdef CFG_CHECKSUM_EN
    cyc(1'b0, 1'b1, m_xor);
`endif
  endtask

  task automatic test_reset();
    rst_cyc();
    rst_cyc();
    checks++; if (bus.io_configs_out !== '0) begin errors++; $display("FAIL reset_configs got %h want 0", bus.io_configs_out); end
    checks++; if (bus.io_word_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.io_word_cnt); end
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.io_busy); end
    checks++; if (bus.io_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.io_done); end
    checks++; if (bus.io_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.io_err); end
    checks++; if (bus.io_d_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.io_d_in_ready); end
  endtask

  task automatic test_sequential_load();
    logic [WW-1:0] xs;
    cyc(1'b1, 1'b0, '0);
    checks++; if (bus.io_busy !== 1'b1) begin errors++; $display("FAIL seq_busy_start got %b want 1", bus.io_busy); end
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.io_d_in_ready !== 1'b1) begin errors++; $display("FAIL seq_ready k=%0d got %b want 1", k, bus.io_d_in_ready); end
      checks++; if (bus.io_done !== 1'b0) begin errors++; $display("FAIL seq_done_early k=%0d got %b want 0", k, bus.io_done); end
      cyc(1'b0, 1'b1, WW'(k));
      checks++; if (bus.io_word_cnt !== CW'(k + 1)) begin errors++; $display("FAIL seq_cnt k=%0d got %0d want %0d", k, bus.io_word_cnt, k + 1); end
    end
`ifdef CFG_CHECKSUM_EN
    xs = '0;
    for (int k = 0; k < NW; k++) xs ^= WW'(k);
    checks++; if (bus.io_d_in_ready !== 1'b1) begin errors++; $display("FAIL seq_ready_ck got %b want 1", bus.io_d_in_ready); end
    cyc(1'b0, 1'b1, xs);
    checks++; if (bus.io_err !== 1'b0) begin errors++; $display("FAIL seq_err got %b want 0", bus.io_err); end
`else
    xs = '0;
`endif
    checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL seq_done got %b want 1", bus.io_done); end
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL seq_busy got %b want 0", bus.io_busy); end
    checks++; if (bus.io_d_in_ready !== 1'b0) begin errors++; $display("FAIL seq_ready_done got %b want 0", bus.io_d_in_ready); end
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.io_configs_out[WW*k +: WW] !== WW'(k)) begin errors++; $display("FAIL seq_word k=%0d got %h want %h", k, bus.io_configs_out[WW*k +: WW], k); end
    end
  endtask

  task automatic test_toggle_valid();
    logic [WW-1:0] d;
    bit vld;
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 200 && m_load; i++) begin
      vld = (i % 2) == 1;
      d   = (m_cnt < NW) ? WW'(m_cnt) : m_xor;
      cyc(1'b0, vld, d);
      checks++; if (bus.io_word_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL tog_cnt i=%0d got %0d want %0d", i, bus.io_word_cnt, m_cnt); end
    end
    checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL tog_done got %b want 1 (timeout or early stop)", bus.io_done); end
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.io_configs_out[WW*k +: WW] !== WW'(k)) begin errors++; $display("FAIL tog_word k=%0d got %h want %h", k, bus.io_configs_out[WW*k +: WW], k); end
    end
  endtask

  task automatic test_restart();
    logic [WW-1:0] ones [NW];
    logic [WW-1:0] w10;
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, $urandom);
    w10 = m_words[10];
    cyc(1'b1, 1'b1, 32'h1234_5678);
    checks++; if (bus.io_word_cnt !== '0) begin errors++; $display("FAIL rst_seq_cnt got %0d want 0", bus.io_word_cnt); end
    checks++; if (bus.io_configs_out[WW*10 +: WW] !== w10) begin errors++; $display("FAIL restart_dropped got %h want %h", bus.io_configs_out[WW*10 +: WW], w10); end
    checks++; if (bus.io_configs_out !== m_flat()) begin errors++; $display("FAIL restart_kept got %h want %h", bus.io_configs_out, m_flat()); end
    for (int k = 0; k < NW; k++) ones[k] = 32'hFFFF_FFFF;
    stream_all(ones);
    checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", bus.io_done); end
    checks++; if (bus.io_configs_out !== {(WW*NW){1'b1}}) begin errors++; $display("FAIL restart_ones got %h want all ones", bus.io_configs_out); end
  endtask

  task automatic test_reset_mid_load();
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, $urandom | 32'h1);
    checks++; if (bus.io_word_cnt !== CW'(20)) begin errors++; $display("FAIL mid_cnt got %0d want 20", bus.io_word_cnt); end
    reset = 1'b1;
    bus.io_d_in_valid = 1'b1;
    bus.io_d_in = 32'hA5A5_A5A5;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    bus.io_d_in_valid = 1'b0;
    checks++; if (bus.io_configs_out !== '0) begin errors++; $display("FAIL mid_configs got %h want 0", bus.io_configs_out); end
    checks++; if (bus.io_d_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", bus.io_d_in_ready); end
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.io_busy); end
    checks++; if (bus.io_word_cnt !== '0) begin errors++; $display("FAIL mid_cnt0 got %0d want 0", bus.io_word_cnt); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
      checks++; if (bus.io_configs_out !== '0) begin errors++; $display("FAIL mid_ignore i=%0d got %h want 0", i, bus.io_configs_out); end
      checks++; if (bus.io_word_cnt !== '0) begin errors++; $display("FAIL mid_ignore_cnt i=%0d got %0d want 0", i, bus.io_word_cnt); end
    end
  endtask

  task automatic test_ignore_idle_done();
    logic [WW-1:0] rnd [NW];
    logic [WW*NW-1:0] snap;
    snap = bus.io_configs_out;
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (bus.io_configs_out !== snap) begin errors++; $display("FAIL idle_ignore got %h want %h", bus.io_configs_out, snap); end
    checks++; if (bus.io_d_in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", bus.io_d_in_ready); end
    for (int k = 0; k < NW; k++) rnd[k] = $urandom;
    cyc(1'b1, 1'b0, '0);
    stream_all(rnd);
    snap = m_flat();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
      checks++; if (bus.io_configs_out !== snap) begin errors++; $display("FAIL done_ignore i=%0d got %h want %h", i, bus.io_configs_out, snap); end
      checks++; if (bus.io_d_in_ready !== 1'b0) begin errors++; $display("FAIL done_ready i=%0d got %b want 0", i, bus.io_d_in_ready); end
      checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL done_level i=%0d got %b want 1", i, bus.io_done); end
    end
  endtask

  task automatic test_random();
    bit st, vld;
    logic [WW-1:0] d;
    for (int i = 0; i < 800; i++) begin
      st  = m_load ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 3) == 0);
      vld = $urandom_range(0, 9) < 7;
      d   = $urandom;
      if (m_cnt == NW && $urandom_range(0, 1) == 1) d = m_xor;
      cyc(st, vld, d);
      checks++; if (bus.io_configs_out !== m_flat()) begin errors++; $display("FAIL rnd_configs i=%0d got %h want %h", i, bus.io_configs_out, m_flat()); end
      checks++; if (bus.io_word_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt i=%0d got %0d want %0d", i, bus.io_word_cnt, m_cnt); end
      checks++; if (bus.io_d_in_ready !== m_load) begin errors++; $display("FAIL rnd_ready i=%0d got %b want %b", i, bus.io_d_in_ready, m_load); end
      checks++; if (bus.io_busy !== m_load) begin errors++; $display("FAIL rnd_busy i=%0d got %b want %b", i, bus.io_busy, m_load); end
      checks++; if (bus.io_done !== m_done) begin errors++; $display("FAIL rnd_done i=%0d got %b want %b", i, bus.io_done, m_done); end
      checks++; if (bus.io_err !== m_err) begin errors++; $display("FAIL rnd_err i=%0d got %b want %b", i, bus.io_err, m_err); end
    end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b1, 1'b0, '0);
      for (int k = 1; k <= NW; k++) cyc(1'b0, 1'b1, WW'(k));
      checks++; if (bus.io_done !== 1'b0) begin errors++; $display("FAIL ck_wait pass=%0d got done=%b want 0", pass, bus.io_done); end
      cyc(1'b0, 1'b1, (pass == 0) ? 32'h0000_0024 : 32'h0000_0025);
      checks++; if (bus.io_err !== (pass == 1)) begin errors++; $display("FAIL ck_err pass=%0d got %b want %b", pass, bus.io_err, pass == 1); end
      checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL ck_done pass=%0d got %b want 1", pass, bus.io_done); end
      checks++; if (bus.io_word_cnt !== CW'(NW + 1)) begin errors++; $display("FAIL ck_cnt pass=%0d got %0d want %0d", pass, bus.io_word_cnt, NW + 1); end
      for (int k = 0; k < NW; k++) begin
        checks++; if (bus.io_configs_out[WW*k +: WW] !== WW'(k + 1)) begin errors++; $display("FAIL ck_word pass=%0d k=%0d got %h want %h", pass, k, bus.io_configs_out[WW*k +: WW], k + 1); end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.io_start = 1'b0;
    bus.io_d_in_valid = 1'b0;
    bus.io_d_in = '0;
    model_reset();
    test_reset();
    test_sequential_load();
    test_toggle_valid();
    test_restart();
    test_reset_mid_load();
    test_ignore_idle_done();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
